// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the multi-slave APB master bridge.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DECERR = 2'd3
   } apb_state_e;

   // Width of the slave index field; never narrower than one bit.
   function automatic int sel_bits(input int num_slaves);
      return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
   endfunction

   // Width of the wait-state counter; must be able to hold the value timeout.
   function automatic int cnt_bits(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_multi_slave_master_if.sv
// CPU request port and per-slave APB bus bundled together.
// Handshake: a request is taken on the rising edge where mvalid && mready;
// the CPU must hold its request fields stable while mvalid is high and
// mready is low. Completion is the one-cycle mdone pulse, with mrdata and
// mslverr valid in that cycle and held until the next completion.
interface apb_multi_slave_master_if #(
   parameter int ADDR_SIZE  = 32,
   parameter int DATA_SIZE  = 32,
   parameter int PROT_SIZE  = 3,
   parameter int STRB_SIZE  = DATA_SIZE / 8,
   parameter int NUM_SLAVES = 4
);
   logic                             mvalid;
   logic                             mready;
   logic                             mwrite;
   logic [ADDR_SIZE-1:0]             maddr;
   logic [DATA_SIZE-1:0]             mwdata;
   logic [STRB_SIZE-1:0]             mstrb;
   logic [PROT_SIZE-1:0]             mprot;
   logic [DATA_SIZE-1:0]             mrdata;
   logic                             mslverr;
   logic                             mdone;
   logic [NUM_SLAVES-1:0]            psel;
   logic                             penable;
   logic                             pwrite;
   logic [ADDR_SIZE-1:0]             paddr;
   logic [DATA_SIZE-1:0]             pwdata;
   logic [STRB_SIZE-1:0]             pstrb;
   logic [PROT_SIZE-1:0]             pprot;
   logic [NUM_SLAVES*DATA_SIZE-1:0]  prdata;
   logic [NUM_SLAVES-1:0]            pready;
   logic [NUM_SLAVES-1:0]            pslverr;

   // Bridge view: takes CPU requests, drives the APB bus.
   modport master (
      input  mvalid, mwrite, maddr, mwdata, mstrb, mprot,
      output mready, mrdata, mslverr, mdone,
      output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      input  prdata, pready, pslverr
   );

   // Environment view: CPU side plus the APB slaves.
   modport slave (
      output mvalid, mwrite, maddr, mwdata, mstrb, mprot,
      input  mready, mrdata, mslverr, mdone,
      input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_addr_decoder.sv
// Maps a request address onto a slave index and flags addresses that fall
// outside every slave region.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int ADDR_SIZE       = 32,
   parameter int NUM_SLAVES      = 4,
   parameter int SLAVE_ADDR_BITS = 8,
   localparam int SEL_W          = sel_bits(NUM_SLAVES)
) (
   input  logic [ADDR_SIZE-1:0] addr,
   output logic [SEL_W-1:0]     idx,
   output logic                 valid
);
   localparam int HI = SLAVE_ADDR_BITS + SEL_W;

   logic hi_zero;
   logic idx_ok;
   logic unused_low;

   assign idx        = addr[SLAVE_ADDR_BITS +: SEL_W];
   assign idx_ok     = (32'(idx) < 32'(NUM_SLAVES));
   // Offset bits inside a region play no part in the decode.
   assign unused_low = ^addr[SLAVE_ADDR_BITS-1:0];

   generate
      if (ADDR_SIZE > HI) begin : g_hi
         assign hi_zero = ~|addr[ADDR_SIZE-1:HI];
      end else begin : g_nohi
         assign hi_zero = 1'b1;
      end
   endgenerate

   assign valid = idx_ok & hi_zero;
endmodule

// File: rtl/apb_multi_slave_master.sv
// APB4 master bridge: one CPU request at a time, decoded to one of
// NUM_SLAVES selects, SETUP/ACCESS with unlimited wait states bounded by an
// optional timeout. All bus and CPU outputs are registered.
module apb_multi_slave_master
   import apb_pkg::*;
#(
   parameter int ADDR_SIZE       = 32,
   parameter int DATA_SIZE       = 32,
   parameter int PROT_SIZE       = 3,
   parameter int STRB_SIZE       = DATA_SIZE / 8,
   parameter int NUM_SLAVES      = 4,
   parameter int SLAVE_ADDR_BITS = 8,
   parameter int TIMEOUT         = 16
) (
   input  logic                      pclk,
   input  logic                      presetn,
   apb_multi_slave_master_if.master  bus,
   output apb_state_e                state_dbg
);
   localparam int SEL_W = sel_bits(NUM_SLAVES);
   localparam int CNT_W = cnt_bits(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   apb_state_e            state;
   logic [CNT_W-1:0]      cnt;
   logic [SEL_W-1:0]      idx_q;
   logic [SEL_W-1:0]      dec_idx;
   logic                  dec_ok;
   logic [NUM_SLAVES-1:0] dec_onehot;
   logic [DATA_SIZE-1:0]  sel_rdata;
   logic                  sel_ready;
   logic                  sel_err;

   apb_addr_decoder #(
      .ADDR_SIZE       (ADDR_SIZE),
      .NUM_SLAVES      (NUM_SLAVES),
      .SLAVE_ADDR_BITS (SLAVE_ADDR_BITS)
   ) u_dec (
      .addr  (bus.maddr),
      .idx   (dec_idx),
      .valid (dec_ok)
   );

   assign state_dbg = state;

   // One-hot select for the slave addressed by the incoming request.
   always_comb begin
      dec_onehot = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         dec_onehot[i] = (dec_idx == SEL_W'(i));
      end
   end

   // Response mux for the latched slave; other slaves' responses never reach the FSM.
   always_comb begin
      sel_rdata = '0;
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == SEL_W'(i)) begin
            sel_rdata = bus.prdata[i*DATA_SIZE +: DATA_SIZE];
            sel_ready = bus.pready[i];
            sel_err   = bus.pslverr[i];
         end
      end
   end

   // Transfer sequencer with registered CPU and APB outputs.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state       <= IDLE;
         cnt         <= '0;
         idx_q       <= '0;
         bus.mready  <= 1'b0;
         bus.mrdata  <= '0;
         bus.mslverr <= 1'b0;
         bus.mdone   <= 1'b0;
         bus.psel    <= '0;
         bus.penable <= 1'b0;
         bus.pwrite  <= 1'b0;
         bus.paddr   <= '0;
         bus.pwdata  <= '0;
         bus.pstrb   <= '0;
         bus.pprot   <= '0;
      end else begin
         bus.mdone <= 1'b0;
         case (state)
            IDLE: begin
               bus.mready <= 1'b1;
               if (bus.mvalid && bus.mready) begin
                  bus.mready <= 1'b0;
                  idx_q      <= dec_idx;
                  if (dec_ok) begin
                     // The APB fields only move for a transfer that reaches the bus.
                     bus.psel   <= dec_onehot;
                     bus.pwrite <= bus.mwrite;
                     bus.paddr  <= bus.maddr;
                     bus.pwdata <= bus.mwdata;
                     bus.pstrb  <= bus.mwrite ? bus.mstrb : '0;
                     bus.pprot  <= bus.mprot;
                     state      <= SETUP;
                  end else begin
                     state <= DECERR;
                  end
               end
            end
            SETUP: begin
               bus.penable <= 1'b1;
               cnt         <= '0;
               state       <= ACCESS;
            end
            ACCESS: begin
               if (sel_ready) begin
                  bus.mslverr <= sel_err;
                  if (!bus.pwrite) begin
                     bus.mrdata <= sel_rdata;
                  end
                  bus.mdone   <= 1'b1;
                  bus.mready  <= 1'b1;
                  bus.psel    <= '0;
                  bus.penable <= 1'b0;
                  state       <= IDLE;
               end else if ((TIMEOUT != 0) && (cnt == CNT_MAX)) begin
                  bus.mslverr <= 1'b1;
                  bus.mrdata  <= '0;
                  bus.mdone   <= 1'b1;
                  bus.mready  <= 1'b1;
                  bus.psel    <= '0;
                  bus.penable <= 1'b0;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DECERR: begin
               bus.mslverr <= 1'b1;
               bus.mrdata  <= '0;
               bus.mdone   <= 1'b1;
               bus.mready  <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_multi_slave_master.sv
// Directed bench for the multi-slave APB master: a vector table of single
// transfers plus hand-written back-to-back and mid-transfer reset sequences.
module tb_apb_multi_slave_master;
   import apb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int PW = 3;
   localparam int SW = 4;
   localparam int NS = 4;
   localparam int NV = 10;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          waits;      // ACCESS cycles before PREADY; -1 = never
      logic        err_wait;   // PSLVERR driven while PREADY low
      logic        err_ready;  // PSLVERR driven with PREADY
      logic        noise;      // toggle unselected PREADY each cycle
      logic [31:0] rdata;
      logic        decerr;
      logic [3:0]  exp_psel;
      logic [3:0]  exp_pstrb;
      int          exp_done;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   logic       pclk;
   logic       presetn;
   apb_state_e state_dbg;
   int         total;
   int         bad;
   vec_t       vecs[NV];
   logic [7:0] exp_q[$];

   apb_multi_slave_master_if #(
      .ADDR_SIZE(AW), .DATA_SIZE(DW), .PROT_SIZE(PW), .STRB_SIZE(SW), .NUM_SLAVES(NS)
   ) bus ();

   apb_multi_slave_master #(
      .ADDR_SIZE(AW), .DATA_SIZE(DW), .PROT_SIZE(PW), .STRB_SIZE(SW),
      .NUM_SLAVES(NS), .SLAVE_ADDR_BITS(8), .TIMEOUT(16)
   ) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // clock / watchdog
   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] st, input logic [2:0] pr, input int wt,
                               input logic ew, input logic er, input logic nz,
                               input logic [31:0] rd, input logic de, input logic [3:0] xps,
                               input logic [3:0] xst, input int xd, input logic xe,
                               input logic [31:0] xr);
      vec_t v;
      v.write = w;  v.addr = a;  v.wdata = wd;  v.strb = st;  v.prot = pr;
      v.waits = wt; v.err_wait = ew; v.err_ready = er; v.noise = nz; v.rdata = rd;
      v.decerr = de; v.exp_psel = xps; v.exp_pstrb = xst; v.exp_done = xd;
      v.exp_err = xe; v.exp_rdata = xr;
      return v;
   endfunction

   // slave models: selected slave follows the vector, the rest misbehave
   task automatic drive_slaves(input vec_t v, input int sl, input int k);
      logic r;
      logic [31:0] kk;
      kk = k;
      for (int i = 0; i < NS; i++) begin
         if (i == sl && !v.decerr) begin
            r = (v.waits >= 0) && (k >= 2 + v.waits);
            bus.pready[i]            = r;
            bus.pslverr[i]           = r ? v.err_ready : v.err_wait;
            bus.prdata[i*DW +: DW]   = v.rdata;
         end else begin
            bus.pready[i]            = v.noise ? kk[0] : 1'b1;
            bus.pslverr[i]           = 1'b1;
            bus.prdata[i*DW +: DW]   = 32'hDEAD0000 | i;
         end
      end
   endtask

   task automatic wait_ready(input string name);
      for (int i = 0; i < 20 && bus.mready !== 1'b1; i++) @(negedge pclk);
      check({name, "_mready"}, bus.mready, 1'b1);
   endtask

   task automatic run_vec(input vec_t v, input int n);
      int    sl;
      int    done_k;
      int    bad_seq;
      string t;
      t = $sformatf("v%0d", n);
      sl = int'(v.addr[9:8]);
      done_k = -1;
      bad_seq = 0;
      wait_ready(t);
      bus.mvalid = 1'b1;
      bus.mwrite = v.write;
      bus.maddr  = v.addr;
      bus.mwdata = v.wdata;
      bus.mstrb  = v.strb;
      bus.mprot  = v.prot;
      drive_slaves(v, sl, 0);
      @(posedge pclk);
      @(negedge pclk);
      bus.mvalid = 1'b0;
      check({t, "_psel_t1"}, bus.psel, v.exp_psel);
      check({t, "_penable_t1"}, bus.penable, 1'b0);
      check({t, "_state_t1"}, state_dbg, v.decerr ? DECERR : SETUP);
      if (!v.decerr) begin
         check({t, "_paddr"}, bus.paddr, v.addr);
         check({t, "_pwdata"}, bus.pwdata, v.wdata);
         check({t, "_pwrite"}, bus.pwrite, v.write);
         check({t, "_pprot"}, bus.pprot, v.prot);
         check({t, "_pstrb"}, bus.pstrb, v.exp_pstrb);
      end
      for (int k = 1; k <= 40; k++) begin
         if (k > 1) @(negedge pclk);
         if (bus.mdone === 1'b1) begin
            done_k = k;
            break;
         end
         if (bus.psel !== v.exp_psel || bus.penable !== ((k >= 2) && !v.decerr) ||
             bus.mready !== 1'b0) bad_seq++;
         drive_slaves(v, sl, k);
      end
      check({t, "_done_cycle"}, done_k, v.exp_done);
      check({t, "_bus_seq"}, bad_seq, 0);
      check({t, "_mslverr"}, bus.mslverr, v.exp_err);
      check({t, "_mrdata"}, bus.mrdata, v.exp_rdata);
      check({t, "_bus_idle_at_done"}, {bus.psel, bus.penable}, 5'b0);
      check({t, "_mready_at_done"}, bus.mready, 1'b1);
      @(negedge pclk);
      check({t, "_mdone_pulse"}, bus.mdone, 1'b0);
   endtask

   function automatic logic [111:0] all_outs();
      return {bus.mready, bus.mdone, bus.psel, bus.penable, bus.pwrite, bus.paddr,
              bus.pwdata, bus.pstrb, bus.pprot, bus.mrdata, bus.mslverr};
   endfunction

   initial begin
      int n_done;
      int idle_bad;
      logic [7:0] e;
      total = 0;
      bad = 0;
      presetn = 1'b0;
      bus.mvalid = 1'b0;
      bus.mwrite = 1'b0;
      bus.maddr = '0;
      bus.mwdata = '0;
      bus.mstrb = '0;
      bus.mprot = '0;
      bus.prdata = '0;
      bus.pready = '0;
      bus.pslverr = '0;

      vecs[0] = mk(1, 32'h102, 32'h01234567, 4'hF, 3'b011, 0, 0, 0, 0, 32'h11110000, 0, 4'b0010, 4'hF, 3, 0, 32'h0);
      vecs[1] = mk(0, 32'h305, 32'h0, 4'hF, 3'b000, 3, 0, 0, 0, 32'h78254535, 0, 4'b1000, 4'h0, 6, 0, 32'h78254535);
      vecs[2] = mk(0, 32'h400, 32'h0, 4'hF, 3'b000, 0, 0, 0, 0, 32'h0, 1, 4'b0000, 4'h0, 2, 1, 32'h0);
      vecs[3] = mk(0, 32'h010, 32'h55, 4'hF, 3'b010, 1, 0, 0, 0, 32'hA5A50001, 0, 4'b0001, 4'h0, 4, 0, 32'hA5A50001);
      vecs[4] = mk(0, 32'h1F0, 32'h0, 4'hF, 3'b000, -1, 0, 0, 0, 32'h0, 0, 4'b0010, 4'h0, 19, 1, 32'h0);
      vecs[5] = mk(1, 32'h2FC, 32'hDEADBEEF, 4'b0101, 3'b001, 2, 1, 1, 1, 32'h22220000, 0, 4'b0100, 4'b0101, 5, 1, 32'h0);
      vecs[6] = mk(0, 32'h280, 32'h0, 4'hF, 3'b000, 2, 1, 0, 1, 32'h13579BDF, 0, 4'b0100, 4'h0, 5, 0, 32'h13579BDF);
      vecs[7] = mk(0, 32'h80000000, 32'h0, 4'hF, 3'b000, 0, 0, 0, 0, 32'h0, 1, 4'b0000, 4'h0, 2, 1, 32'h0);
      vecs[8] = mk(1, 32'h3FF, 32'hCAFEF00D, 4'b1001, 3'b101, 0, 0, 0, 0, 32'h77777777, 0, 4'b1000, 4'b1001, 3, 0, 32'h0);
      vecs[9] = mk(0, 32'h3A0, 32'h0, 4'hF, 3'b110, 0, 0, 0, 0, 32'h0BADBEEF, 0, 4'b1000, 4'h0, 3, 0, 32'h0BADBEEF);

      // reset state
      #1;
      check("reset_outputs", all_outs(), 112'h0);
      check("reset_state", state_dbg, IDLE);
      repeat (3) @(negedge pclk);
      presetn = 1'b1;
      @(negedge pclk);

      for (int n = 0; n < NV; n++) run_vec(vecs[n], n);

      // back-to-back: mvalid held across two writes
      wait_ready("b2b");
      for (int i = 0; i < NS; i++) begin
         bus.pready[i] = 1'b1;
         bus.pslverr[i] = 1'b0;
      end
      exp_q.push_back(8'd3);
      exp_q.push_back(8'd6);
      n_done = 0;
      bus.mvalid = 1'b1;
      bus.mwrite = 1'b1;
      bus.maddr  = 32'h002;
      bus.mwdata = 32'h11112222;
      bus.mstrb  = 4'hF;
      bus.mprot  = 3'b000;
      @(posedge pclk);
      for (int k = 1; k <= 12; k++) begin
         @(negedge pclk);
         if (k == 1) begin
            check("b2b_psel_first", bus.psel, 4'b0001);
            bus.maddr  = 32'h203;
            bus.mwdata = 32'h33334444;
         end
         if (k == 4) begin
            check("b2b_psel_second", bus.psel, 4'b0100);
            check("b2b_paddr_second", bus.paddr, 32'h203);
            check("b2b_pwdata_second", bus.pwdata, 32'h33334444);
            bus.mvalid = 1'b0;
         end
         if (bus.mdone === 1'b1) begin
            n_done++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
            check("b2b_done_cycle", k, e);
         end
      end
      check("b2b_done_count", n_done, 2);
      check("b2b_mslverr", bus.mslverr, 1'b0);
      check("b2b_mrdata_held", bus.mrdata, 32'h0BADBEEF);

      // reset in the middle of an ACCESS wait
      wait_ready("rst");
      bus.pready = '0;
      bus.mvalid = 1'b1;
      bus.mwrite = 1'b0;
      bus.maddr  = 32'h100;
      @(posedge pclk);
      @(negedge pclk);
      bus.mvalid = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
      check("rst_pre_state", state_dbg, ACCESS);
      #2;
      presetn = 1'b0;
      #1;
      check("rst_async_outputs", all_outs(), 112'h0);
      check("rst_async_state", state_dbg, IDLE);
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
      idle_bad = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge pclk);
         if (bus.mdone !== 1'b0 || bus.psel !== 4'b0 || bus.penable !== 1'b0) idle_bad++;
      end
      check("rst_no_activity", idle_bad, 0);
      check("rst_mready_after", bus.mready, 1'b1);
      check("rst_state_after", state_dbg, IDLE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
